// File: rtl/vending_ctrl_multi.sv
// Multi-item vending controller: coin credit accumulation, per-item stock,
// single-cycle vend pulse and a greedy change-coin stream with valid/ready.
module vending_ctrl_multi #(
    parameter int ITEMS      = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    parameter int MAX_CREDIT = 100,
    parameter logic [ITEMS*CREDIT_W-1:0] PRICES = {8'd30, 8'd25, 8'd20, 8'd15}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coin_valid,
    input  logic [1:0]               coin,
    input  logic                     sel_valid,
    input  logic [$clog2(ITEMS)-1:0] sel,
    input  logic                     cancel,
    input  logic                     restock,
    input  logic                     change_ready,
    output logic [CREDIT_W-1:0]      credit,
    output logic                     busy,
    output logic                     coin_reject,
    output logic                     sel_nack,
    output logic                     vend_valid,
    output logic [$clog2(ITEMS)-1:0] vend_item,
    output logic                     change_valid,
    output logic [1:0]               change_coin,
    output logic [ITEMS-1:0]         sold_out
);

    localparam int SEL_W = $clog2(ITEMS);
    localparam int TAB_N = 1 << SEL_W;
    localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  INIT_VAL = STOCK_W'(INIT_STOCK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  vend_valid_q, vend_valid_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  sel_nack_q, sel_nack_d;
    logic [SEL_W-1:0]      vend_item_q, vend_item_d;
    logic                  restock_en;
    logic                  vend_en;

    logic [CREDIT_W-1:0]   price_tab [TAB_N];
    logic                  item_ok   [TAB_N];
    logic                  sel_ok;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W:0]     credit_sum;
    logic [1:0]            chg_code;
    logic [CREDIT_W-1:0]   chg_val;

    // Lookup tables cover every encodable sel; codes >= ITEMS are never sellable.
    generate
        for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
            if (gi < ITEMS) begin : g_real
                assign price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
                assign item_ok[gi]   = ~sold_out[gi];
            end else begin : g_none
                assign price_tab[gi] = '0;
                assign item_ok[gi]   = 1'b0;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < ITEMS; gi++) begin : g_item
            logic [STOCK_W-1:0] stock_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stock_q <= INIT_VAL;
                end else if (restock_en) begin
                    stock_q <= INIT_VAL;
                end else if (vend_en && (sel == SEL_W'(gi))) begin
                    stock_q <= stock_q - STOCK_W'(1);
                end
            end

            assign sold_out[gi] = (stock_q == '0);
        end
    endgenerate

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = CREDIT_W'(5);
            2'b10:   coin_val = CREDIT_W'(10);
            2'b11:   coin_val = CREDIT_W'(20);
            default: coin_val = '0;
        endcase
    end

    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign sel_ok     = item_ok[sel] && (credit_q >= price_tab[sel]);

    // Greedy change: largest coin not exceeding the remaining credit.
    always_comb begin
        chg_code = 2'b00;
        chg_val  = '0;
        if (credit_q >= CREDIT_W'(20)) begin
            chg_code = 2'b11;
            chg_val  = CREDIT_W'(20);
        end else if (credit_q >= CREDIT_W'(10)) begin
            chg_code = 2'b10;
            chg_val  = CREDIT_W'(10);
        end else if (credit_q >= CREDIT_W'(5)) begin
            chg_code = 2'b01;
            chg_val  = CREDIT_W'(5);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_nack_q    <= 1'b0;
            vend_item_q   <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_valid_q  <= vend_valid_d;
            coin_reject_q <= coin_reject_d;
            sel_nack_q    <= sel_nack_d;
            vend_item_q   <= vend_item_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_valid_d  = 1'b0;
        coin_reject_d = 1'b0;
        sel_nack_d    = 1'b0;
        vend_item_d   = vend_item_q;
        restock_en    = 1'b0;
        vend_en       = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                restock_en = restock && (state_q == S_IDLE);
                // cancel > sel_valid > coin_valid; losers are refused outright.
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    sel_nack_d    = sel_valid;
                    if (state_q == S_CREDIT) begin
                        state_d = S_CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (sel_ok) begin
                        vend_en      = 1'b1;
                        vend_valid_d = 1'b1;
                        vend_item_d  = sel;
                        credit_d     = credit_q - price_tab[sel];
                        state_d      = S_VEND;
                    end else begin
                        sel_nack_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if ((coin != 2'b00) && (credit_sum <= MAX_EXT)) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                sel_nack_d    = sel_valid;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                sel_nack_d    = sel_valid;
                if (change_ready) begin
                    credit_d = credit_q - chg_val;
                    if (credit_q == chg_val) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign credit       = credit_q;
    assign busy         = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign coin_reject  = coin_reject_q;
    assign sel_nack     = sel_nack_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = (state_q == S_CHANGE);
    assign change_coin  = (state_q == S_CHANGE) ? chg_code : 2'b00;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Bench for vending_ctrl_multi: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_vending_ctrl_multi;

    localparam int ITEMS = 4;
    localparam int CW    = 8;
    localparam int INIT  = 8;
    localparam int MAXC  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin_valid;
    logic [1:0]    coin;
    logic          sel_valid;
    logic [1:0]    sel;
    logic          cancel;
    logic          restock;
    logic          change_ready;
    logic [CW-1:0] credit;
    logic          busy;
    logic          coin_reject;
    logic          sel_nack;
    logic          vend_valid;
    logic [1:0]    vend_item;
    logic          change_valid;
    logic [1:0]    change_coin;
    logic [3:0]    sold_out;

    vending_ctrl_multi #(
        .ITEMS(ITEMS), .CREDIT_W(CW), .STOCK_W(4), .INIT_STOCK(INIT),
        .MAX_CREDIT(MAXC), .PRICES({8'd30, 8'd25, 8'd20, 8'd15})
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .restock(restock),
        .change_ready(change_ready), .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .sel_nack(sel_nack), .vend_valid(vend_valid),
        .vend_item(vend_item), .change_valid(change_valid),
        .change_coin(change_coin), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    // Model: credit in rupees, stock counts, and what the machine is doing
    // (0 = taking orders, 1 = dispensing this cycle, 2 = paying out change).
    int price [ITEMS] = '{15, 20, 25, 30};
    int m_credit;
    int m_stock [ITEMS];
    int m_phase;
    int m_rej, m_nack, m_vv, m_vi, m_hs;
    int n_vec = 0;
    int n_err = 0;

    function automatic int coin_rs(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 20;
            default: return 0;
        endcase
    endfunction

    function automatic int greedy(input int c);
        if (c >= 20) return 20;
        if (c >= 10) return 10;
        if (c >= 5)  return 5;
        return 0;
    endfunction

    function automatic int greedy_code(input int c);
        if (c >= 20) return 3;
        if (c >= 10) return 2;
        if (c >= 5)  return 1;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int v;
        bit do_restock;
        m_hs = 0;
        if (rst) begin
            m_credit = 0;
            foreach (m_stock[i]) m_stock[i] = INIT;
            m_phase = 0;
            m_rej = 0; m_nack = 0; m_vv = 0; m_vi = 0;
            return;
        end
        m_rej = 0; m_nack = 0; m_vv = 0;
        case (m_phase)
            0: begin
                do_restock = restock && (m_credit == 0);
                if (cancel) begin
                    m_rej  = coin_valid;
                    m_nack = sel_valid;
                    if (m_credit > 0) m_phase = 2;
                end else if (sel_valid) begin
                    m_rej = coin_valid;
                    if (m_credit >= price[sel] && m_stock[sel] > 0) begin
                        m_credit -= price[sel];
                        m_stock[sel] -= 1;
                        m_vv = 1;
                        m_vi = sel;
                        m_phase = 1;
                    end else begin
                        m_nack = 1;
                    end
                end else if (coin_valid) begin
                    v = coin_rs(coin);
                    if (v > 0 && m_credit + v <= MAXC) m_credit += v;
                    else m_rej = 1;
                end
                if (do_restock) foreach (m_stock[i]) m_stock[i] = INIT;
            end
            1: begin
                m_rej  = coin_valid;
                m_nack = sel_valid;
                m_phase = (m_credit > 0) ? 2 : 0;
            end
            default: begin
                m_rej  = coin_valid;
                m_nack = sel_valid;
                if (change_ready) begin
                    m_credit -= greedy(m_credit);
                    m_hs = 1;
                    if (m_credit == 0) m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int so;
        so = 0;
        for (int i = 0; i < ITEMS; i++) if (m_stock[i] == 0) so |= (1 << i);
        check("credit", int'(credit), m_credit);
        check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        check("coin_reject", int'(coin_reject), m_rej);
        check("sel_nack", int'(sel_nack), m_nack);
        check("vend_valid", int'(vend_valid), m_vv);
        if (m_vv != 0) check("vend_item", int'(vend_item), m_vi);
        check("change_valid", int'(change_valid), (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) check("change_coin", int'(change_coin), greedy_code(m_credit));
        check("sold_out", int'(sold_out), so);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (m_vv != 0) $display("vend item=%0d credit_left=%0d", m_vi, m_credit);
        if (m_hs != 0) $display("change paid, credit_left=%0d", m_credit);
    endtask

    task automatic clr();
        rst = 1'b0; coin_valid = 1'b0; coin = 2'b00; sel_valid = 1'b0;
        sel = 2'd0; cancel = 1'b0; restock = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        clr(); coin_valid = 1'b1; coin = c; tick();
    endtask

    task automatic drain(input int limit);
        int n;
        clr();
        change_ready = 1'b1;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", int'(busy), 0);
    endtask

    initial begin
        clr();
        change_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("t1_rst_credit", int'(credit), 0);
        check("t1_rst_busy", int'(busy), 0);
        check("t1_rst_vend_item", int'(vend_item), 0);
        check("t1_rst_change_coin", int'(change_coin), 0);
        check("t1_rst_sold_out", int'(sold_out), 0);

        // 1: Rs10 + Rs5, buy item 0 (15): exact payment, no change
        put_coin(2'b10);
        check("t1_credit10", int'(credit), 10);
        put_coin(2'b01);
        check("t1_credit15", int'(credit), 15);
        clr(); sel_valid = 1'b1; sel = 2'd0; tick();
        check("t1_vend", int'(vend_valid), 1);
        check("t1_item", int'(vend_item), 0);
        check("t1_credit0", int'(credit), 0);
        clr(); tick();
        check("t1_idle_busy", int'(busy), 0);
        check("t1_no_change", int'(change_valid), 0);

        // 2: 40 in, buy item 2 (25), change 10 then 5
        put_coin(2'b11);
        put_coin(2'b11);
        check("t2_credit40", int'(credit), 40);
        clr(); sel_valid = 1'b1; sel = 2'd2; tick();
        check("t2_vend_item", int'(vend_item), 2);
        check("t2_credit15", int'(credit), 15);
        clr(); change_ready = 1'b1; tick();
        check("t2_coin10", int'(change_coin), 2);
        tick();
        check("t2_coin5", int'(change_coin), 1);
        check("t2_credit5", int'(credit), 5);
        tick();
        check("t2_done_valid", int'(change_valid), 0);
        check("t2_done_credit", int'(credit), 0);

        // 3: Rs20 then cancel with hopper stalled for 3 cycles
        change_ready = 1'b0;
        put_coin(2'b11);
        clr(); cancel = 1'b1; tick();
        clr();
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", int'(change_valid), 1);
            check("t3_hold_coin", int'(change_coin), 3);
            tick();
        end
        change_ready = 1'b1; tick();
        check("t3_credit0", int'(credit), 0);
        check("t3_idle", int'(busy), 0);

        // 4: overflow reject at 95, then simultaneous sel + coin
        change_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_coin(2'b11);
        put_coin(2'b10);
        put_coin(2'b01);
        check("t4_credit95", int'(credit), 95);
        put_coin(2'b10);
        check("t4_reject", int'(coin_reject), 1);
        check("t4_credit_kept", int'(credit), 95);
        clr(); tick();
        check("t4_reject_pulse", int'(coin_reject), 0);
        clr(); sel_valid = 1'b1; sel = 2'd3; coin_valid = 1'b1; coin = 2'b01; tick();
        check("t4_vend", int'(vend_valid), 1);
        check("t4_reject2", int'(coin_reject), 1);
        check("t4_credit65", int'(credit), 65);
        drain(20);

        // 5: empty item 1, refused sale, restock
        for (int i = 0; i < INIT; i++) begin
            put_coin(2'b11);
            clr(); sel_valid = 1'b1; sel = 2'd1; tick();
            clr(); tick();
        end
        check("t5_sold_out", int'(sold_out), 4'b0010);
        put_coin(2'b11);
        clr(); sel_valid = 1'b1; sel = 2'd1; tick();
        check("t5_nack", int'(sel_nack), 1);
        check("t5_credit20", int'(credit), 20);
        clr(); cancel = 1'b1; change_ready = 1'b1; tick();
        drain(10);
        clr(); restock = 1'b1; tick();
        check("t5_restocked", int'(sold_out), 0);

        // 6: reset while paying out 15
        change_ready = 1'b0;
        put_coin(2'b10);
        put_coin(2'b01);
        clr(); cancel = 1'b1; tick();
        check("t6_in_change", int'(change_valid), 1);
        clr(); rst = 1'b1; tick();
        check("t6_credit0", int'(credit), 0);
        check("t6_no_change", int'(change_valid), 0);
        check("t6_busy", int'(busy), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 399) == 0);
            coin_valid   = ($urandom_range(0, 99) < 45);
            coin         = 2'($urandom_range(0, 3));
            sel_valid    = ($urandom_range(0, 99) < 20);
            sel          = 2'($urandom_range(0, 3));
            cancel       = ($urandom_range(0, 99) < 5);
            restock      = ($urandom_range(0, 99) < 3);
            change_ready = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
